// File: rtl/pwm_decoder_if.sv
// Bundle of the PWM input and the measurement results of pwm_decoder.
// The master side supplies the PWM waveform and observes the results;
// the slave side (the decoder) samples the waveform and reports.
interface pwm_decoder_if #(
    parameter int WIDTH = 8
);
    logic             pwm_in;
    logic             measure_valid;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty;
    logic             stuck;
    logic             level;

    modport master (
        output pwm_in,
        input  measure_valid, period, duty, stuck, level
    );

    modport slave (
        input  pwm_in,
        output measure_valid, period, duty, stuck, level
    );
endinterface

// File: rtl/pwm_decoder.sv
// PWM receiver: synchronizes an asynchronous PWM input, measures each
// rising-edge-to-rising-edge period and its high time in clk cycles, and
// reports both with a one-cycle strobe. A missing rising edge for TIMEOUT
// cycles flags a constant-level (0% / 100% duty) input via stuck.
module pwm_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**WIDTH - 1
) (
    input  logic          clk,
    input  logic          reset,
    pwm_decoder_if.slave  pwm_bus
);

    localparam logic [WIDTH-1:0] LP_TIMEOUT = WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_STUCK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_q;
    logic                   w_pwm_s;
    logic                   w_rise;
    logic                   w_timeout;
    logic                   w_report;

    logic [WIDTH-1:0]       r_p_cnt;
    logic [WIDTH-1:0]       r_h_cnt;

    logic                   r_vld_p1;
    logic [WIDTH-1:0]       r_period_p1;
    logic [WIDTH-1:0]       r_duty_p1;

    // Counters stop at TIMEOUT so a long constant level can never wrap
    // around and masquerade as a short period.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                                 input logic             inc);
        if (inc && (v < LP_TIMEOUT))
            return v + WIDTH'(1);
        return v;
    endfunction

    assign w_pwm_s   = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_pwm_s & ~r_pwm_q;
    assign w_timeout = (r_p_cnt == LP_TIMEOUT);

    // Input synchronizer and one-cycle delay for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_pwm_q <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_bus.pwm_in};
            r_pwm_q <= w_pwm_s;
        end
    end

    // Window counters: a rise counts as the first cycle (and first high
    // sample) of a new window; every later cycle adds one period cycle and
    // one high cycle when the synchronized input is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_cnt <= '0;
            r_h_cnt <= '0;
        end else if (w_rise) begin
            r_p_cnt <= WIDTH'(1);
            r_h_cnt <= WIDTH'(1);
        end else begin
            r_p_cnt <= sat_inc(r_p_cnt, 1'b1);
            r_h_cnt <= sat_inc(r_h_cnt, w_pwm_s);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; a rise always beats a simultaneous timeout, and only
    // a rise that closes a complete window in MEASURE produces a report.
    always_comb begin
        w_state_nxt = r_state;
        w_report    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise)
                    w_state_nxt = S_MEASURE;
                else if (w_timeout)
                    w_state_nxt = S_STUCK;
            end
            S_MEASURE: begin
                if (w_rise)
                    w_report = 1'b1;
                else if (w_timeout)
                    w_state_nxt = S_STUCK;
            end
            S_STUCK: begin
                if (w_rise)
                    w_state_nxt = S_MEASURE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---- report stage: results registered one cycle after the closing rise
    // Result registers hold their value until the next completed window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1    <= 1'b0;
            r_period_p1 <= '0;
            r_duty_p1   <= '0;
        end else begin
            r_vld_p1 <= w_report;
            if (w_report) begin
                r_period_p1 <= r_p_cnt;
                r_duty_p1   <= r_h_cnt;
            end
        end
    end

    assign pwm_bus.measure_valid = r_vld_p1;
    assign pwm_bus.period        = r_period_p1;
    assign pwm_bus.duty          = r_duty_p1;
    assign pwm_bus.stuck         = (r_state == S_STUCK);
    assign pwm_bus.level         = w_pwm_s;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: directed PWM scenarios followed by randomized
// segments. Every sample driven is fed to a waveform-level reference that
// finds rising edges in the raw sample stream and queues the expected
// (period, duty) of each window that must be reported; a separate monitor
// pops the queue whenever the decoder strobes measure_valid.
module tb_pwm_decoder;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 16;

    typedef struct {
        int period;
        int duty;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pwm_decoder_if #(.WIDTH(WIDTH)) bus ();

    pwm_decoder #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pwm_bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference state: previous sample, whether a rise has been seen since
    // reset, samples since that rise (rise included), high samples since it
    bit   m_prev = 1'b0;
    bit   m_have = 1'b0;
    int   m_gap  = 0;
    int   m_hc   = 0;

    // last values the decoder is required to be holding on period/duty
    int   exp_last_p = 0;
    int   exp_last_d = 0;
    bit   prev_vld   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one sample and update the reference: a 0->1 step in the sample
    // stream closes the previous window, which is reportable only if it began
    // with a rise after reset and was shorter than TIMEOUT.
    task automatic step(input bit v);
        bus.pwm_in = v;
        if (v && !m_prev) begin
            if (m_have && (m_gap < TIMEOUT))
                exp_q.push_back('{period: m_gap, duty: m_hc});
            m_have = 1'b1;
            m_gap  = 1;
            m_hc   = 1;
        end else if (m_have) begin
            if (m_gap < 1000) m_gap++;
            if (v && m_hc < 1000) m_hc++;
        end
        m_prev = v;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pwm(input int p, input int d, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++)
                step(i < d);
    endtask

    task automatic constant(input bit v, input int n);
        for (int i = 0; i < n; i++)
            step(v);
    endtask

    task automatic do_reset();
        check("pending_before_reset", exp_q.size(), 0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.pwm_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        m_prev = 1'b0;
        m_have = 1'b0;
        m_gap  = 0;
        m_hc   = 0;
        check("reset_valid",  32'(bus.measure_valid), 0);
        check("reset_period", 32'(bus.period), 0);
        check("reset_duty",   32'(bus.duty), 0);
        check("reset_stuck",  32'(bus.stuck), 0);
        check("reset_level",  32'(bus.level), 0);
        reset = 1'b0;
    endtask

    task automatic check_stuck(input bit exp_stuck);
        check("stuck", 32'(bus.stuck), 32'(exp_stuck));
        check("hold_period", 32'(bus.period), exp_last_p);
        check("hold_duty",   32'(bus.duty), exp_last_d);
    endtask

    // Monitor: consume one expected report per strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_last_p = 0;
                exp_last_d = 0;
            end
            if (bus.measure_valid) begin
                check("valid_spacing", 32'(prev_vld), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual period=%0d duty=%0d required=no report (t=%0t)",
                             bus.period, bus.duty, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("period", 32'(bus.period), e.period);
                    check("duty",   32'(bus.duty), e.duty);
                    exp_last_p = e.period;
                    exp_last_d = e.duty;
                end
            end
            prev_vld = bus.measure_valid;
        end
    end

    initial begin
        int mode, p, d, n;
        bit v;
        bus.pwm_in = 1'b0;
        do_reset();

        // steady 50% duty, then single-cycle low / high windows
        run_pwm(8, 4, 4);
        check_stuck(1'b0);
        run_pwm(8, 7, 3);
        run_pwm(8, 1, 3);
        check_stuck(1'b0);

        // constant low from reset: stuck after the timeout, nothing reported
        do_reset();
        constant(1'b0, TIMEOUT - 2);
        check_stuck(1'b0);
        constant(1'b0, 10);
        check_stuck(1'b1);
        check("stuck_level_low", 32'(bus.level), 0);

        // constant high from reset
        do_reset();
        constant(1'b1, TIMEOUT + SYNC_STAGES + 6);
        check_stuck(1'b1);
        check("stuck_level_high", 32'(bus.level), 1);

        // parameter change at a period boundary, then input stops
        do_reset();
        run_pwm(8, 4, 3);
        run_pwm(6, 1, 3);
        constant(1'b0, TIMEOUT + 8);
        check_stuck(1'b1);
        check("held_period_6", 32'(bus.period), 6);

        // reset in the middle of a window, then resume
        run_pwm(8, 4, 3);
        constant(1'b1, 3);
        constant(1'b0, 2);
        do_reset();
        run_pwm(8, 4, 3);
        check_stuck(1'b0);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            mode = int'($urandom_range(0, 9));
            if (mode == 0) begin
                v = 1'($urandom_range(0, 1));
                constant(v, TIMEOUT + 8);
                check_stuck(1'b1);
                check("rand_stuck_level", 32'(bus.level), 32'(v));
            end else if (mode == 1) begin
                run_pwm(8, 4, 2);
                constant(1'b1, 3);
                constant(1'b0, 2);
                do_reset();
            end else begin
                p = int'($urandom_range(2, 14));
                d = int'($urandom_range(1, p - 1));
                n = int'($urandom_range(3, 5));
                run_pwm(p, d, n);
                check("rand_not_stuck", 32'(bus.stuck), 0);
            end
        end

        constant(1'b0, 6);
        check("drain_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
